mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, shall set the wait cycles inserted before each access (legal range 0..7).
REQ-002 Parameter AWIDTH, default 5, shall set the address width (array depth 2**AWIDTH).
REQ-003 Parameter DWIDTH, default 8, shall set the data width.
REQ-004 clk  input  1  clock; all state shall update on rising edge.
REQ-005 rst_  input  1  reset, asynchronous, active-low.
REQ-006 mem_rd  input  1  read strobe, level, may be held several cycles.
REQ-007 mem_wr  input  1  write strobe, level, may be held several cycles.
REQ-008 addr  input  AWIDTH  word address.
REQ-009 data_in  input  DWIDTH  write data.
REQ-010 data_out  output  DWIDTH  registered read data.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high while a request is in progress.
REQ-013 err  output  1  one-cycle protocol-error pulse.
REQ-014 parity_err  output  1  one-cycle read parity-mismatch pulse.

Function
REQ-015 A request shall be a rising edge of mem_rd or mem_wr, detected against a registered copy of each strobe.
REQ-016 FSM states shall be IDLE, WAIT, ACCESS, DONE; busy shall be 1 in every state except IDLE.
REQ-017 In IDLE with one strobe edge, the block shall latch addr, data_in and the operation type, then go to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-018 Entering WAIT, the wait counter shall load WAIT_STATES-1 and decrement once per cycle; WAIT shall exit to ACCESS on the cycle the counter is 0.
REQ-019 In ACCESS, a read shall load data_out from array[addr_q] and a write shall store data_q to array[addr_q]; next state shall be DONE.
REQ-020 In DONE, ready shall be 1 for exactly one cycle; next state shall be IDLE.
REQ-021 Latency: from the clock edge that samples the strobe edge to the ready-high cycle shall be WAIT_STATES+2 cycles.
REQ-022 Simultaneous mem_rd and mem_wr rising edges in IDLE shall pulse err for one cycle and start no operation.
REQ-023 Any strobe rising edge while busy shall pulse err for one cycle; that request shall be dropped and the current operation shall continue unaffected.
REQ-024 Deasserting a strobe mid-operation shall not abort the operation.
REQ-025 data_out shall hold its value until the next read reaches ACCESS; writes shall not change data_out.
REQ-026 Every address value shall be valid; there shall be no out-of-range condition or wrap logic.
REQ-027 A new request may be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-028 Asserting rst_ shall immediately force state IDLE, wait counter 0, strobe history 0, data_out 0, and ready, busy, err, parity_err 0.
REQ-029 Array contents shall not be reset.
REQ-030 Reset asserted before the ACCESS clock edge shall prevent the pending write.

Configuration
REQ-031 With MEM_PARITY_EN defined:
- each array word shall store DWIDTH data bits plus one even-parity bit computed on write;
- a read shall recompute parity in ACCESS and, on mismatch, pulse parity_err in the DONE cycle alongside ready;
- data_out shall still present the stored data.
REQ-032 Without MEM_PARITY_EN, the array shall be DWIDTH wide and parity_err shall be constant 0.

Structure
REQ-033 The shared package typedefs shall hold resp_state_t (IDLE, WAIT, ACCESS, DONE) and the default WAIT_STATES constant.
REQ-034 Storage shall be a sub-module mem_array (synchronous write, registered read, width DWIDTH or DWIDTH+1).

Verification
REQ-035 Write then read: write 8'hA5 to addr 5'h03, then read 5'h03 -> data_out=8'hA5; ready 4 cycles after each strobe edge (WAIT_STATES=2).
REQ-036 Zero-wait: with WAIT_STATES=0, read addr 5'h1F holding 8'h3C -> ready 2 cycles after the edge, data_out=8'h3C.
REQ-037 Collision: mem_rd and mem_wr rising in the same cycle -> err=1 for 1 cycle, busy stays 0, array unchanged.
REQ-038 Busy overlap: second mem_rd edge during WAIT -> err pulse; the first read completes with correct data and a single ready pulse.
REQ-039 Reset mid-write: assert rst_ in WAIT of a write of 8'hFF to 5'h07 (previously 8'h11) -> all outputs 0, later read returns 8'h11.
REQ-040 Parity (MEM_PARITY_EN): backdoor-flip a stored data bit at 5'h02, then read -> parity_err=1 in the same cycle as ready; without the macro parity_err stays 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM state type and default wait-state count for mem_responder.
package mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} resp_state_t;
    localparam int DEF_WAIT_STATES = 2;
endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: word storage with synchronous write and registered, resettable read port.
module mem_array #(
    parameter int AWIDTH = 5,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              we,
    input  logic              re,
    input  logic [AWIDTH-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    always_ff @(posedge clk or negedge rst_)
        if (!rst_) rdata <= '0;
        else if (re) rdata <= mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: edge-triggered memory responder with wait states and collision/overlap error pulses.
// Defining MEM_PARITY_EN adds an even-parity bit per word and a read parity_err pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic              parity_err
);
`ifdef MEM_PARITY_EN
    localparam int MW = DWIDTH + 1;
`else
    localparam int MW = DWIDTH;
`endif
    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    resp_state_t       state, state_nx;
    logic [2:0]        cnt;
    logic              rd_q, wr_q, op_rd;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic [MW-1:0]     wdata, rdata;
    logic              rd_edge, wr_edge, start;

    assign rd_edge = mem_rd & ~rd_q;
    assign wr_edge = mem_wr & ~wr_q;
    assign start   = (state == IDLE) && (rd_edge ^ wr_edge);

    always_ff @(posedge clk or negedge rst_)
        if (!rst_) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:   if (cnt == 3'd0) state_nx = ACCESS;
            ACCESS: state_nx = DONE;
            DONE:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = state != IDLE;
        ready = state == DONE;
`ifdef MEM_PARITY_EN
        parity_err = ready && op_rd && (^rdata);
`else
        parity_err = 1'b0;
`endif
    end

    // Edges while busy, or both strobes together in IDLE, are rejected with err.
    always_ff @(posedge clk or negedge rst_)
        if (!rst_) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            err    <= 1'b0;
            cnt    <= 3'd0;
            op_rd  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rd_q <= mem_rd;
            wr_q <= mem_wr;
            err  <= (state == IDLE) ? (rd_edge & wr_edge) : (rd_edge | wr_edge);
            if (start) begin
                addr_q <= addr;
                data_q <= data_in;
                op_rd  <= rd_edge;
                cnt    <= WS_M1;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end

`ifdef MEM_PARITY_EN
    assign wdata = {^data_q, data_q};
`else
    assign wdata = data_q;
`endif
    assign data_out = rdata[DWIDTH-1:0];

    mem_array #(.AWIDTH(AWIDTH), .WIDTH(MW)) u_array (
        .clk   (clk),
        .rst_  (rst_),
        .we    (state == ACCESS && !op_rd),
        .re    (state == ACCESS && op_rd),
        .addr  (addr_q),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule
